// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the forwarding/hazard controller.
// Holds operand-mux select codes and the shadow-stage record.
package pipe_pkg;

    localparam int REG_BITS = 5;

    // Select codes in Mux3_1 input order
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
        logic                memread;
    } shadow_t;

    // A stage produces register r; r0 is hardwired and never produced
    function automatic logic writes_reg(
        input shadow_t             s,
        input logic [REG_BITS-1:0] r
    );
        return s.valid && s.regwrite && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/forward_unit_if.sv
// ID-side request and EX-side control bundle of the forwarding unit.
// master drives the ID instruction; slave is the forwarding unit.
interface forward_unit_if #(
    parameter int REG_BITS  = pipe_pkg::REG_BITS,
    parameter int CNT_WIDTH = 32
);

    logic                 ID_Valid;
    logic [REG_BITS-1:0]  ID_Rs;
    logic [REG_BITS-1:0]  ID_Rt;
    logic [REG_BITS-1:0]  ID_Rd;
    logic                 ID_RegWrite;
    logic                 ID_MemRead;
    logic                 Flush;
    logic [1:0]           FwdA_SEL;
    logic [1:0]           FwdB_SEL;
    logic                 Stall;
    logic [CNT_WIDTH-1:0] Stall_Count;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_Rd,
        output ID_RegWrite, ID_MemRead, Flush,
        input  FwdA_SEL, FwdB_SEL, Stall, Stall_Count
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_Rd,
        input  ID_RegWrite, ID_MemRead, Flush,
        output FwdA_SEL, FwdB_SEL, Stall, Stall_Count
    );

endinterface

// File: rtl/fwd_select.sv
// Priority compare for one EX operand: newest producer wins.
// Purely combinational from shadow state, so glitch-free vs ID inputs.
module fwd_select
    import pipe_pkg::*;
(
    input  logic                ex_valid,
    input  logic [REG_BITS-1:0] src,
    input  shadow_t             mem,
    input  shadow_t             wb,
    output logic [1:0]          sel
);

    // memread of the older stages plays no part in forwarding
    logic unused_bits;
    assign unused_bits = mem.memread ^ wb.memread;

    // MEM is newer than WB, so it is checked first
    always_comb begin
        sel = FWD_RF;
        if (!ex_valid) begin
            sel = FWD_RF;
        end else if (writes_reg(mem, src)) begin
            sel = FWD_MEM;
        end else if (writes_reg(wb, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Mirrors EX/MEM/WB in a shadow pipeline and drives operand selects.
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_BITS  = pipe_pkg::REG_BITS,
    parameter int CNT_WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    forward_unit_if.slave  bus
);

    shadow_t              ex;
    shadow_t              mem;
    shadow_t              wb;
    logic [REG_BITS-1:0]  ex_rs;
    logic [REG_BITS-1:0]  ex_rt;
    logic [CNT_WIDTH-1:0] count;
    logic                 raw;
    logic                 stall;
    logic                 bubble;

    // Load in EX whose result the ID instruction needs next cycle
    always_comb begin
        raw = 1'b0;
        if (ex.valid && ex.memread && (ex.rd != '0) && bus.ID_Valid) begin
            raw = (ex.rd == bus.ID_Rs) || (ex.rd == bus.ID_Rt);
        end
        stall  = raw && !bus.Flush;
        bubble = stall || bus.Flush || !bus.ID_Valid;
    end

    // Shadow pipeline shift; EX takes a bubble on stall/flush/idle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex    <= '0;
            mem   <= '0;
            wb    <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
        end else begin
            wb  <= mem;
            mem <= ex;
            if (bubble) begin
                ex    <= '0;
                ex_rs <= '0;
                ex_rt <= '0;
            end else begin
                ex.valid    <= 1'b1;
                ex.rd       <= bus.ID_Rd;
                ex.regwrite <= bus.ID_RegWrite;
                ex.memread  <= bus.ID_MemRead;
                ex_rs       <= bus.ID_Rs;
                ex_rt       <= bus.ID_Rt;
            end
        end
    end

    // Stall cycles counted, holding at all-ones
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (stall && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    fwd_select u_sel_a (
        .ex_valid (ex.valid),
        .src      (ex_rs),
        .mem      (mem),
        .wb       (wb),
        .sel      (bus.FwdA_SEL)
    );

    fwd_select u_sel_b (
        .ex_valid (ex.valid),
        .src      (ex_rt),
        .mem      (mem),
        .wb       (wb),
        .sel      (bus.FwdB_SEL)
    );

    assign bus.Stall       = stall;
    assign bus.Stall_Count = count;

endmodule
